level_ctrl_fsm: RTL and testbench
=================================

// Module: level_ctrl_fsm
// PURPOSE
//  Parametrised per-level game controller for the claw/miner gameplay loop.
//  Sequences swing -> dive -> retract per throw, using a table with NUM_LOOT loot types.
//  Accumulates level and total score, runs a goal check at timer expiry, and advances
//  through NUM_LEVELS levels. Sits between the object drawers (drawing-request inputs)
//  and the claw/loot movers (move_speed).
// PARAMETERS
//  NUM_LOOT    4        number of loot types; LT_W = max(1,$clog2(NUM_LOOT))
//  NUM_LEVELS  4        levels per game; LV_W = max(1,$clog2(NUM_LEVELS))
//  SCORE_W     16       width of score accumulators and goal
//  SPEED_W     4        width of move_speed
//  DEF_SPEED   4        claw speed when swinging, diving, or retracting empty
//  LOOT_SCORE  packed [NUM_LOOT][SCORE_W] score per type; default {50,20,10,0}, type0 = 0
//  LOOT_SPEED  packed [NUM_LOOT][SPEED_W] retract speed per type; default {1,2,3,4}
// PORTS
//  clk             in   1        system clock
//  reset           in   1        asynchronous, active-high reset
//  start_level     in   1        pulse: begin level (IDLE) / restart game (GAME_OVER)
//  claw_dr         in   1        claw drawing request
//  borders_dr      in   1        border drawing request
//  miner_dr        in   1        miner drawing request
//  loot_dr         in   1        any-loot drawing request
//  loot_type       in   LT_W     type of loot under current pixel, valid with loot_dr
//  timer_endedN    in   1        low = level timer expired
//  enter_pressed   in   1        player action, level-sensitive
//  goal            in   SCORE_W  level goal, sampled in LEVEL_END
//  move_speed      out  SPEED_W  claw/loot speed, 0 when not moving
//  hit_pulse       out  1        one-cycle pulse on dive collision
//  grab_pulse      out  1        one-cycle pulse when hit is loot (subset of hit_pulse)
//  credit_pulse    out  1        one-cycle pulse when loot is credited at miner
//  grabbed_type    out  LT_W     latched type of held loot
//  holding         out  1        loot currently attached to claw
//  level_score     out  SCORE_W  score within current level
//  total_score     out  SCORE_W  score across game
//  level_num       out  LV_W     current level index, 0-based
//  level_ended     out  1        high while in LEVEL_END
//  level_won       out  1        high in LEVEL_END when level_score >= goal
//  game_over       out  1        high in GAME_OVER
//  game_won        out  1        high in GAME_OVER if last level was passed
// BEHAVIOUR
//  Reset: state IDLE. All outputs and internal registers are 0.
//  Registered outputs appear 1 clk after the state entered. move_speed is combinational from state.
//  Collision: claw_hit = claw_dr & (borders_dr | loot_dr). Miner is not a dive target.
//  IDLE: on start_level -> SWING; clear level_score and holding.
//  SWING: move_speed = DEF_SPEED. If !timer_endedN -> LEVEL_END, else if enter_pressed -> DIVE.
//  DIVE: move_speed = DEF_SPEED. If !timer_endedN -> LEVEL_END (timer has priority).
//    Else on claw_hit -> RETRACT with hit_pulse = 1.
//    If loot_dr is also set: grab_pulse = 1, holding <= 1, grabbed_type <= loot_type.
//  RETRACT: move_speed = holding ? LOOT_SPEED[grabbed_type] : DEF_SPEED.
//    If !timer_endedN -> LEVEL_END with no credit (loot lost; timer beats return in same cycle).
//    Else on claw_dr & miner_dr -> SWING.
//    On return with holding: credit_pulse = 1 and LOOT_SCORE[grabbed_type] is added to both scores.
//    Then clear holding.
//  Score add saturates at 2^SCORE_W-1 independently per accumulator; no wrap.
//  loot_type >= NUM_LOOT is treated as type 0 (no score, DEF_SPEED).
//  LEVEL_END: move_speed = 0. level_won = (level_score >= goal), evaluated each cycle.
//    On enter_pressed:
//      - won, level_num < NUM_LEVELS-1: level_num++, level_score <= 0 -> IDLE.
//      - won on last level: game_won <= 1 -> GAME_OVER.
//      - lost: game_won <= 0 -> GAME_OVER.
//  GAME_OVER: move_speed = 0. On start_level: clear level_num, both scores, game_won -> SWING.
//  Simultaneous events: at most one transition per clk; priority is timer > collision/return > enter.
//  Reset mid-operation aborts immediately to IDLE with all outputs 0.
//  Pulses are single-cycle because the state leaves DIVE/RETRACT in the same edge.
// TESTING
//  Dive onto type 3 (score 50, speed 1) then return -> hit/grab 1 clk each; speed 1; level/total 50.
//  Dive onto border only -> hit_pulse=1, grab_pulse=0, speed DEF_SPEED, no score change.
//  timer_endedN low in the same cycle as claw_dr&miner_dr while holding -> LEVEL_END, score unchanged.
//  SCORE_W=6, repeated type-3 credits -> saturates at 63, never wraps.
//  goal=40, score 50, enter in LEVEL_END on level 0 -> level_num=1, level_score=0, total kept, IDLE.
//  Last level lost -> GAME_OVER, game_won=0; start_level -> all scores 0, level_num 0; reset -> IDLE.

Source files
------------

// File: rtl/level_ctrl_fsm.sv
// Per-level controller for the claw/miner game: swing -> dive -> retract per throw,
// saturating level/total scoring, goal check at timer expiry and level/game advance.
module level_ctrl_fsm #(
   parameter int NUM_LOOT   = 4,
   parameter int NUM_LEVELS = 4,
   parameter int SCORE_W    = 16,
   parameter int SPEED_W    = 4,
   parameter int DEF_SPEED  = 4,
   parameter logic [NUM_LOOT-1:0][SCORE_W-1:0] LOOT_SCORE =
      {SCORE_W'(50), SCORE_W'(20), SCORE_W'(10), SCORE_W'(0)},
   parameter logic [NUM_LOOT-1:0][SPEED_W-1:0] LOOT_SPEED =
      {SPEED_W'(1), SPEED_W'(2), SPEED_W'(3), SPEED_W'(4)},
   localparam int LT_W = (NUM_LOOT   > 1) ? $clog2(NUM_LOOT)   : 1,
   localparam int LV_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start_level,
   input  logic               claw_dr,
   input  logic               borders_dr,
   input  logic               miner_dr,
   input  logic               loot_dr,
   input  logic [LT_W-1:0]    loot_type,
   input  logic               timer_endedN,
   input  logic               enter_pressed,
   input  logic [SCORE_W-1:0] goal,
   output logic [SPEED_W-1:0] move_speed,
   output logic               hit_pulse,
   output logic               grab_pulse,
   output logic               credit_pulse,
   output logic [LT_W-1:0]    grabbed_type,
   output logic               holding,
   output logic [SCORE_W-1:0] level_score,
   output logic [SCORE_W-1:0] total_score,
   output logic [LV_W-1:0]    level_num,
   output logic               level_ended,
   output logic               level_won,
   output logic               game_over,
   output logic               game_won
);

   typedef enum logic [2:0] {
      IDLE, SWING, DIVE, RETRACT, LEVEL_END, GAME_OVER
   } state_t;

   state_t             state_q, state_d;
   logic               holding_q, holding_d;
   logic [LT_W-1:0]    grabbed_type_q, grabbed_type_d;
   logic [SCORE_W-1:0] level_score_q, level_score_d;
   logic [SCORE_W-1:0] total_score_q, total_score_d;
   logic [LV_W-1:0]    level_num_q, level_num_d;
   logic               game_won_q, game_won_d;

   logic               claw_hit;
   logic               claw_home;
   logic [LT_W-1:0]    loot_type_s;
   logic [SCORE_W-1:0] credit_val;

   function automatic logic [SCORE_W-1:0] satAdd(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
      logic [SCORE_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
   endfunction

   assign claw_hit    = claw_dr & (borders_dr | loot_dr);
   assign claw_home   = claw_dr & miner_dr;
   // Unknown loot codes behave as the worthless type 0.
   assign loot_type_s = (32'(loot_type) < NUM_LOOT) ? loot_type : '0;
   assign credit_val  = LOOT_SCORE[grabbed_type_q];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         holding_q      <= 1'b0;
         grabbed_type_q <= '0;
         level_score_q  <= '0;
         total_score_q  <= '0;
         level_num_q    <= '0;
         game_won_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         holding_q      <= holding_d;
         grabbed_type_q <= grabbed_type_d;
         level_score_q  <= level_score_d;
         total_score_q  <= total_score_d;
         level_num_q    <= level_num_d;
         game_won_q     <= game_won_d;
      end
   end

   // The timer is checked first in every moving state so it wins over hit/return/enter.
   always_comb begin
      state_d        = state_q;
      holding_d      = holding_q;
      grabbed_type_d = grabbed_type_q;
      level_score_d  = level_score_q;
      total_score_d  = total_score_q;
      level_num_d    = level_num_q;
      game_won_d     = game_won_q;
      case (state_q)
         IDLE: begin
            if (start_level) begin
               state_d       = SWING;
               level_score_d = '0;
               holding_d     = 1'b0;
            end
         end
         SWING: begin
            if (!timer_endedN)      state_d = LEVEL_END;
            else if (enter_pressed) state_d = DIVE;
         end
         DIVE: begin
            if (!timer_endedN) begin
               state_d = LEVEL_END;
            end else if (claw_hit) begin
               state_d = RETRACT;
               if (loot_dr) begin
                  holding_d      = 1'b1;
                  grabbed_type_d = loot_type_s;
               end
            end
         end
         RETRACT: begin
            if (!timer_endedN) begin
               state_d   = LEVEL_END;
               holding_d = 1'b0;
            end else if (claw_home) begin
               state_d   = SWING;
               holding_d = 1'b0;
               if (holding_q) begin
                  level_score_d = satAdd(level_score_q, credit_val);
                  total_score_d = satAdd(total_score_q, credit_val);
               end
            end
         end
         LEVEL_END: begin
            if (enter_pressed) begin
               if (level_score_q >= goal) begin
                  if (32'(level_num_q) < NUM_LEVELS - 1) begin
                     level_num_d   = level_num_q + LV_W'(1);
                     level_score_d = '0;
                     state_d       = IDLE;
                  end else begin
                     game_won_d = 1'b1;
                     state_d    = GAME_OVER;
                  end
               end else begin
                  game_won_d = 1'b0;
                  state_d    = GAME_OVER;
               end
            end
         end
         GAME_OVER: begin
            if (start_level) begin
               level_num_d   = '0;
               level_score_d = '0;
               total_score_d = '0;
               game_won_d    = 1'b0;
               holding_d     = 1'b0;
               state_d       = SWING;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pulses are decoded from the transition itself, so they last exactly one cycle.
   always_comb begin
      move_speed   = '0;
      hit_pulse    = 1'b0;
      grab_pulse   = 1'b0;
      credit_pulse = 1'b0;
      case (state_q)
         SWING: move_speed = SPEED_W'(DEF_SPEED);
         DIVE: begin
            move_speed = SPEED_W'(DEF_SPEED);
            hit_pulse  = timer_endedN & claw_hit;
            grab_pulse = timer_endedN & claw_hit & loot_dr;
         end
         RETRACT: begin
            move_speed   = holding_q ? LOOT_SPEED[grabbed_type_q] : SPEED_W'(DEF_SPEED);
            credit_pulse = timer_endedN & claw_home & holding_q;
         end
         default: move_speed = '0;
      endcase
   end

   assign grabbed_type = grabbed_type_q;
   assign holding      = holding_q;
   assign level_score  = level_score_q;
   assign total_score  = total_score_q;
   assign level_num    = level_num_q;
   assign level_ended  = (state_q == LEVEL_END);
   assign level_won    = (state_q == LEVEL_END) && (level_score_q >= goal);
   assign game_over    = (state_q == GAME_OVER);
   assign game_won     = game_won_q;

endmodule

// File: tb/tb_level_ctrl_fsm.sv
// Directed bench for level_ctrl_fsm: a default instance plus a 6-bit-score instance
// sharing the same stimulus to exercise saturation.
module tb_level_ctrl_fsm;

   logic        clk;
   logic        reset;
   logic        start_level, claw_dr, borders_dr, miner_dr, loot_dr;
   logic [1:0]  loot_type;
   logic        timer_endedN, enter_pressed;
   logic [15:0] goal;

   logic [3:0]  move_speed;
   logic        hit_pulse, grab_pulse, credit_pulse;
   logic [1:0]  grabbed_type;
   logic        holding;
   logic [15:0] level_score, total_score;
   logic [1:0]  level_num;
   logic        level_ended, level_won, game_over, game_won;

   logic [3:0]  sMoveSpeed;
   logic        sHit, sGrab, sCredit;
   logic [1:0]  sGrabbedType;
   logic        sHolding;
   logic [5:0]  sLevelScore, sTotalScore;
   logic [1:0]  sLevelNum;
   logic        sLevelEnded, sLevelWon, sGameOver, sGameWon;

   int assertCount = 0;
   int failCount   = 0;

   level_ctrl_fsm dut (
      .clk(clk), .reset(reset), .start_level(start_level), .claw_dr(claw_dr),
      .borders_dr(borders_dr), .miner_dr(miner_dr), .loot_dr(loot_dr),
      .loot_type(loot_type), .timer_endedN(timer_endedN), .enter_pressed(enter_pressed),
      .goal(goal), .move_speed(move_speed), .hit_pulse(hit_pulse),
      .grab_pulse(grab_pulse), .credit_pulse(credit_pulse), .grabbed_type(grabbed_type),
      .holding(holding), .level_score(level_score), .total_score(total_score),
      .level_num(level_num), .level_ended(level_ended), .level_won(level_won),
      .game_over(game_over), .game_won(game_won)
   );

   level_ctrl_fsm #(.SCORE_W(6)) dutSmall (
      .clk(clk), .reset(reset), .start_level(start_level), .claw_dr(claw_dr),
      .borders_dr(borders_dr), .miner_dr(miner_dr), .loot_dr(loot_dr),
      .loot_type(loot_type), .timer_endedN(timer_endedN), .enter_pressed(enter_pressed),
      .goal(goal[5:0]), .move_speed(sMoveSpeed), .hit_pulse(sHit),
      .grab_pulse(sGrab), .credit_pulse(sCredit), .grabbed_type(sGrabbedType),
      .holding(sHolding), .level_score(sLevelScore), .total_score(sTotalScore),
      .level_num(sLevelNum), .level_ended(sLevelEnded), .level_won(sLevelWon),
      .game_over(sGameOver), .game_won(sGameWon)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge, far from the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic st, input logic cl, input logic bo,
                                input logic mi, input logic lo, input logic [1:0] ty,
                                input logic tn, input logic en);
      start_level   = st;
      claw_dr       = cl;
      borders_dr    = bo;
      miner_dr      = mi;
      loot_dr       = lo;
      loot_type     = ty;
      timer_endedN  = tn;
      enter_pressed = en;
      #1;
   endtask

   task automatic applyIdle();
      applyStimulus(0, 0, 0, 0, 0, 2'd0, 1, 0);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      goal  = 16'd40;
      applyIdle();
      tick();
      tick();
      checkOutput("reset_speed", move_speed, 0);
      checkOutput("reset_level_score", level_score, 0);
      checkOutput("reset_total", total_score, 0);
      checkOutput("reset_level_num", level_num, 0);
      checkOutput("reset_flags", {level_ended, level_won, game_over, game_won, holding}, 0);
      reset = 1'b0;

      $display("[TB] start level and swing");
      applyStimulus(1, 0, 0, 0, 0, 2'd0, 1, 0);
      tick(); applyIdle();
      checkOutput("swing_speed", move_speed, 4);

      applyStimulus(0, 0, 0, 0, 0, 2'd0, 1, 1);
      tick(); applyIdle();
      checkOutput("dive_speed", move_speed, 4);
      checkOutput("dive_no_hit", hit_pulse, 0);

      $display("[TB] grab type 3 and return");
      applyStimulus(0, 1, 0, 0, 1, 2'd3, 1, 0);
      checkOutput("grab3_hit", hit_pulse, 1);
      checkOutput("grab3_grab", grab_pulse, 1);
      tick(); applyIdle();
      checkOutput("grab3_hit_gone", {hit_pulse, grab_pulse}, 0);
      checkOutput("grab3_holding", holding, 1);
      checkOutput("grab3_type", grabbed_type, 3);
      checkOutput("grab3_speed", move_speed, 1);

      applyStimulus(0, 1, 0, 1, 0, 2'd0, 1, 0);
      checkOutput("return3_credit", credit_pulse, 1);
      tick(); applyIdle();
      checkOutput("return3_credit_gone", credit_pulse, 0);
      checkOutput("return3_level", level_score, 50);
      checkOutput("return3_total", total_score, 50);
      checkOutput("return3_holding", holding, 0);
      checkOutput("return3_swing", move_speed, 4);
      checkOutput("small_first_credit", sLevelScore, 50);

      $display("[TB] border hit");
      applyStimulus(0, 0, 0, 0, 0, 2'd0, 1, 1);
      tick();
      applyStimulus(0, 1, 1, 0, 0, 2'd0, 1, 0);
      checkOutput("border_hit", hit_pulse, 1);
      checkOutput("border_grab", grab_pulse, 0);
      tick(); applyIdle();
      checkOutput("border_holding", holding, 0);
      checkOutput("border_speed", move_speed, 4);
      applyStimulus(0, 1, 0, 1, 0, 2'd0, 1, 0);
      checkOutput("border_no_credit", credit_pulse, 0);
      tick(); applyIdle();
      checkOutput("border_score", level_score, 50);

      $display("[TB] second type 3 credit, saturation on 6-bit instance");
      applyStimulus(0, 0, 0, 0, 0, 2'd0, 1, 1);
      tick();
      applyStimulus(0, 1, 0, 0, 1, 2'd3, 1, 0);
      tick();
      applyStimulus(0, 1, 0, 1, 0, 2'd0, 1, 0);
      tick(); applyIdle();
      checkOutput("second_level", level_score, 100);
      checkOutput("second_total", total_score, 100);
      checkOutput("small_sat_level", sLevelScore, 63);
      checkOutput("small_sat_total", sTotalScore, 63);

      $display("[TB] timer beats return while holding");
      applyStimulus(0, 0, 0, 0, 0, 2'd0, 1, 1);
      tick();
      applyStimulus(0, 1, 0, 0, 1, 2'd3, 1, 0);
      tick();
      checkOutput("race_holding", holding, 1);
      applyStimulus(0, 1, 0, 1, 0, 2'd0, 0, 0);
      checkOutput("race_no_credit", credit_pulse, 0);
      tick(); applyIdle();
      checkOutput("race_level_end", level_ended, 1);
      checkOutput("race_score", level_score, 100);
      checkOutput("race_holding_lost", holding, 0);
      checkOutput("race_speed", move_speed, 0);
      checkOutput("small_race_score", sLevelScore, 63);
      checkOutput("won_goal40", level_won, 1);
      goal = 16'd200;
      #1;
      checkOutput("lost_goal200", level_won, 0);
      goal = 16'd40;
      #1;

      $display("[TB] advance to level 1");
      applyStimulus(0, 0, 0, 0, 0, 2'd0, 1, 1);
      tick(); applyIdle();
      checkOutput("adv_level_num", level_num, 1);
      checkOutput("adv_level_score", level_score, 0);
      checkOutput("adv_total", total_score, 100);
      checkOutput("adv_idle", {level_ended, game_over, move_speed}, 0);
      checkOutput("small_adv_total", sTotalScore, 63);

      $display("[TB] pass levels 1 and 2 with goal 0");
      goal = 16'd0;
      for (int lv = 1; lv <= 2; lv++) begin
         applyStimulus(1, 0, 0, 0, 0, 2'd0, 1, 0);
         tick();
         applyStimulus(0, 0, 0, 0, 0, 2'd0, 0, 0);
         tick();
         applyStimulus(0, 0, 0, 0, 0, 2'd0, 1, 1);
         tick(); applyIdle();
      end
      checkOutput("reach_last_level", level_num, 3);

      $display("[TB] lose last level");
      goal = 16'd40;
      applyStimulus(1, 0, 0, 0, 0, 2'd0, 1, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 2'd0, 0, 0);
      tick(); applyIdle();
      checkOutput("last_not_won", level_won, 0);
      applyStimulus(0, 0, 0, 0, 0, 2'd0, 1, 1);
      tick(); applyIdle();
      checkOutput("go_game_over", game_over, 1);
      checkOutput("go_game_won", game_won, 0);
      checkOutput("go_speed", move_speed, 0);
      checkOutput("go_total_kept", total_score, 100);

      $display("[TB] restart game");
      applyStimulus(1, 0, 0, 0, 0, 2'd0, 1, 0);
      tick(); applyIdle();
      checkOutput("restart_level_num", level_num, 0);
      checkOutput("restart_scores", {level_score, total_score}, 0);
      checkOutput("restart_swing", {game_over, move_speed}, 4);

      $display("[TB] timer beats collision in dive, then reset mid-level");
      applyStimulus(0, 0, 0, 0, 0, 2'd0, 1, 1);
      tick();
      applyStimulus(0, 1, 0, 0, 1, 2'd2, 0, 0);
      checkOutput("dive_timer_no_hit", {hit_pulse, grab_pulse}, 0);
      tick(); applyIdle();
      checkOutput("dive_timer_end", level_ended, 1);
      checkOutput("dive_timer_no_hold", holding, 0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_end", level_ended, 0);
      checkOutput("async_reset_speed", move_speed, 0);
      tick();
      reset = 1'b0;
      applyStimulus(1, 0, 0, 0, 0, 2'd0, 1, 0);
      tick(); applyIdle();
      checkOutput("post_reset_swing", move_speed, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
